qgate_sequencer: RTL and testbench

QGATE_SEQUENCER -- requirements
Module: qgate_sequencer

---
 rtl/qgate_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_qgate_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/qgate_sequencer.sv
// Two-qubit state-vector gate sequencer: applies one gate per accepted op to four complex amplitudes.
// Optional op counter output is enabled by defining QGATE_SEQUENCER_OPCNT_EN.
module qgate_sequencer #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op_valid,
  input  logic [2:0]           op_code,
  input  logic                 op_tgt,
  input  logic                 op_last,
  output logic                 op_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic signed [DW-1:0] final_c00_re,
  output logic signed [DW-1:0] final_c00_im,
  output logic signed [DW-1:0] final_c01_re,
  output logic signed [DW-1:0] final_c01_im,
  output logic signed [DW-1:0] final_c10_re,
  output logic signed [DW-1:0] final_c10_im,
  output logic signed [DW-1:0] final_c11_re,
  output logic signed [DW-1:0] final_c11_im
`ifdef QGATE_SEQUENCER_OPCNT_EN
  ,
  output logic [7:0]           op_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [2:0] {
    OP_NOP, OP_H, OP_X, OP_Z, OP_S, OP_CNOT, OP_RSV6, OP_RSV7
  } op_e;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } amp_t;

  // Product width: (DW+1)-bit sum times a sign-extended (FRAC+2)-bit constant.
  localparam int PW = DW + FRAC + 3;

  // Rounded integer square root, used to derive K = round(2^FRAC / sqrt2) at elaboration.
  function automatic int round_isqrt(input longint unsigned x);
    longint unsigned r;
    longint unsigned t;
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    if (x > r * r + r) r = r + 1;
    return int'(r);
  endfunction

  localparam int                    K_INT = round_isqrt(64'd1 << (2 * FRAC - 1));
  localparam logic signed [PW-1:0]  K_S   = PW'(K_INT);
  localparam logic signed [DW-1:0]  ONE   = DW'(1 << FRAC);

  function automatic logic signed [DW-1:0] h_term(input logic signed [DW-1:0] x,
                                                  input logic signed [DW-1:0] y,
                                                  input logic             sub);
    logic signed [DW:0]   s;
    logic signed [PW-1:0] p;
    s = sub ? ((DW+1)'(x) - (DW+1)'(y)) : ((DW+1)'(x) + (DW+1)'(y));
    p = PW'(s) * K_S;
    p = p >>> FRAC;
    return p[DW-1:0];
  endfunction

  function automatic void apply_gate(input op_e op, input amp_t a, input amp_t b,
                                     output amp_t a_n, output amp_t b_n);
    a_n = a;
    b_n = b;
    case (op)
      OP_H: begin
        a_n.re = h_term(a.re, b.re, 1'b0);
        a_n.im = h_term(a.im, b.im, 1'b0);
        b_n.re = h_term(a.re, b.re, 1'b1);
        b_n.im = h_term(a.im, b.im, 1'b1);
      end
      OP_X: begin
        a_n = b;
        b_n = a;
      end
      OP_Z: begin
        b_n.re = -b.re;
        b_n.im = -b.im;
      end
      OP_S: begin
        b_n.re = -b.im;
        b_n.im = b.re;
      end
      default: ;
    endcase
  endfunction

  state_e state_q, state_d;
  amp_t   amp_q [4];
  amp_t   amp_d [4];
  logic   err_q, err_d;
  op_e    op;
  op_e    gate_op;
  logic [1:0] ia, ib;
  amp_t   pa, pb;

`ifdef QGATE_SEQUENCER_OPCNT_EN
  logic [7:0] cnt_q, cnt_d;
`endif

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    for (int i = 0; i < 4; i++) amp_d[i] = amp_q[i];
    op      = op_e'(op_code);
    gate_op = OP_NOP;
    ia      = 2'd0;
    ib      = 2'd0;
    pa      = '0;
    pb      = '0;
`ifdef QGATE_SEQUENCER_OPCNT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          err_d   = 1'b0;
          for (int i = 0; i < 4; i++) amp_d[i] = '0;
          amp_d[0].re = ONE;
`ifdef QGATE_SEQUENCER_OPCNT_EN
          cnt_d = 8'd0;
`endif
        end
      end
      RUN: begin
        if (op_valid) begin
          if (op == OP_RSV6 || op == OP_RSV7) err_d = 1'b1;
          // Pair p: tgt=0 pairs (2p, 2p+1); tgt=1 pairs (p, p+2). CNOT only flips the pair with control=1.
          for (int p = 0; p < 2; p++) begin
            ia = op_tgt ? 2'(p) : 2'(2 * p);
            ib = ia | (op_tgt ? 2'd2 : 2'd1);
            if (op == OP_CNOT) gate_op = (p == 1) ? OP_X : OP_NOP;
            else               gate_op = op;
            apply_gate(gate_op, amp_q[ia], amp_q[ib], pa, pb);
            amp_d[ia] = pa;
            amp_d[ib] = pb;
          end
`ifdef QGATE_SEQUENCER_OPCNT_EN
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
`endif
          if (op_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) amp_q[i] <= '0;
      amp_q[0].re <= ONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      for (int i = 0; i < 4; i++) amp_q[i] <= amp_d[i];
    end
  end

`ifdef QGATE_SEQUENCER_OPCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end
  assign op_count = cnt_q;
`endif

  assign op_ready     = (state_q == RUN);
  assign busy         = (state_q == RUN) || (state_q == DONE);
  assign done         = (state_q == DONE);
  assign err          = err_q;
  assign final_c00_re = amp_q[0].re;
  assign final_c00_im = amp_q[0].im;
  assign final_c01_re = amp_q[1].re;
  assign final_c01_im = amp_q[1].im;
  assign final_c10_re = amp_q[2].re;
  assign final_c10_im = amp_q[2].im;
  assign final_c11_re = amp_q[3].re;
  assign final_c11_im = amp_q[3].im;

endmodule

// File: tb/tb_qgate_sequencer.sv
// Directed self-checking bench for qgate_sequencer (DW=16, FRAC=8); op_count checks
// are compiled in when QGATE_SEQUENCER_OPCNT_EN is defined.
module tb_qgate_sequencer;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset, start, op_valid, op_tgt, op_last;
  logic [2:0] op_code;
  logic op_ready, busy, done, err;
  logic signed [DW-1:0] c00_re, c00_im, c01_re, c01_im, c10_re, c10_im, c11_re, c11_im;
`ifdef QGATE_SEQUENCER_OPCNT_EN
  logic [7:0] op_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] NOP = 3'd0, H = 3'd1, X = 3'd2, Z = 3'd3, S = 3'd4, CNOT = 3'd5, RSV6 = 3'd6;

  qgate_sequencer #(.DW(DW), .FRAC(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .op_valid(op_valid), .op_code(op_code), .op_tgt(op_tgt), .op_last(op_last),
    .op_ready(op_ready), .busy(busy), .done(done), .err(err),
    .final_c00_re(c00_re), .final_c00_im(c00_im),
    .final_c01_re(c01_re), .final_c01_im(c01_im),
    .final_c10_re(c10_re), .final_c10_im(c10_im),
    .final_c11_re(c11_re), .final_c11_im(c11_im)
`ifdef QGATE_SEQUENCER_OPCNT_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic check_amps(input string tag,
                            input int e00r, input int e00i, input int e01r, input int e01i,
                            input int e10r, input int e10i, input int e11r, input int e11i);
    check({tag, ".c00_re"}, int'(c00_re), e00r);
    check({tag, ".c00_im"}, int'(c00_im), e00i);
    check({tag, ".c01_re"}, int'(c01_re), e01r);
    check({tag, ".c01_im"}, int'(c01_im), e01i);
    check({tag, ".c10_re"}, int'(c10_re), e10r);
    check({tag, ".c10_im"}, int'(c10_im), e10i);
    check({tag, ".c11_re"}, int'(c11_re), e11r);
    check({tag, ".c11_im"}, int'(c11_im), e11i);
  endtask

  task automatic check_ctl(input string tag, input int rdy, input int bsy, input int dn, input int er);
    check({tag, ".op_ready"}, int'(op_ready), rdy);
    check({tag, ".busy"},     int'(busy),     bsy);
    check({tag, ".done"},     int'(done),     dn);
    check({tag, ".err"},      int'(err),      er);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] code, input logic tgt, input logic last);
    op_valid = 1'b1;
    op_code  = code;
    op_tgt   = tgt;
    op_last  = last;
    tick();
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_valid = 1'b0; op_code = 3'd0; op_tgt = 1'b0; op_last = 1'b0;
    tick();
    tick();
    check_ctl("reset", 0, 0, 0, 0);
    check_amps("reset", 256, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // Ops presented in IDLE are not accepted.
    do_op(X, 1'b0, 1'b0);
    check_ctl("idle_op", 0, 0, 0, 0);
    check_amps("idle_op", 256, 0, 0, 0, 0, 0, 0, 0);

    // Bell pair.
    do_start();
    check_ctl("bell_start", 1, 1, 0, 0);
    check_amps("bell_start", 256, 0, 0, 0, 0, 0, 0, 0);
    do_op(H, 1'b1, 1'b0);
    check_amps("bell_h", 181, 0, 0, 0, 181, 0, 0, 0);
    do_op(CNOT, 1'b0, 1'b1);
    check_ctl("bell_done", 0, 1, 1, 0);
    check_amps("bell_cnot", 181, 0, 0, 0, 0, 0, 181, 0);
    tick();
    check_ctl("bell_idle", 0, 0, 0, 0);
    check_amps("bell_hold", 181, 0, 0, 0, 0, 0, 181, 0);

    // Double Hadamard: floor rounding leaves 255, not 256.
    do_start();
    do_op(H, 1'b0, 1'b0);
    check_amps("hh_1", 181, 0, 181, 0, 0, 0, 0, 0);
    do_op(H, 1'b0, 1'b1);
    check_amps("hh_2", 255, 0, 0, 0, 0, 0, 0, 0);
    check("hh_done", int'(done), 1);
    tick();

    // Phase: X then S on qubit 0.
    do_start();
    do_op(X, 1'b0, 1'b0);
    check_amps("ph_x", 0, 0, 256, 0, 0, 0, 0, 0);
    do_op(S, 1'b0, 1'b1);
    check_amps("ph_s", 0, 0, 0, 256, 0, 0, 0, 0);
    tick();

    // Stall, ignored start, reserved opcode, Z with negative result, NOP last.
    do_start();
    do_op(H, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_amps("stall", 181, 0, 0, 0, 181, 0, 0, 0);
    end
    do_start();
    check_ctl("ign_start", 1, 1, 0, 0);
    check_amps("ign_start", 181, 0, 0, 0, 181, 0, 0, 0);
    do_op(RSV6, 1'b0, 1'b0);
    check_ctl("rsv6", 1, 1, 0, 1);
    check_amps("rsv6", 181, 0, 0, 0, 181, 0, 0, 0);
    do_op(Z, 1'b1, 1'b0);
    check_amps("z_neg", 181, 0, 0, 0, -181, 0, 0, 0);
`ifdef QGATE_SEQUENCER_OPCNT_EN
    check("cnt_run", int'(op_count), 3);
`endif
    do_op(NOP, 1'b0, 1'b1);
    check_ctl("nop_last", 0, 1, 1, 1);
`ifdef QGATE_SEQUENCER_OPCNT_EN
    check("cnt_last", int'(op_count), 4);
`endif
    tick();
    check("err_sticky_idle", int'(err), 1);
    do_start();
    check_ctl("err_clear", 1, 1, 0, 0);
`ifdef QGATE_SEQUENCER_OPCNT_EN
    check("cnt_clear", int'(op_count), 0);
`endif

    // Asynchronous reset mid-run.
    do_op(H, 1'b1, 1'b0);
    check_amps("pre_rst", 181, 0, 0, 0, 181, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check_ctl("async_rst", 0, 0, 0, 0);
    check_amps("async_rst", 256, 0, 0, 0, 0, 0, 0, 0);
`ifdef QGATE_SEQUENCER_OPCNT_EN
    check("cnt_rst", int'(op_count), 0);
`endif
    do_op(X, 1'b0, 1'b0);
    check_amps("rst_held", 256, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // CNOT with target 1 swaps c01 and c11.
    do_start();
    do_op(X, 1'b1, 1'b0);
    do_op(H, 1'b0, 1'b0);
    check_amps("c_pre", 0, 0, 0, 0, 181, 0, 181, 0);
    do_op(CNOT, 1'b1, 1'b1);
    check_amps("cnot_t1", 0, 0, 181, 0, 181, 0, 0, 0);
    tick();

`ifdef QGATE_SEQUENCER_OPCNT_EN
    // Counter saturation.
    do_start();
    op_valid = 1'b1; op_code = NOP; op_tgt = 1'b0; op_last = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    check("cnt_sat", int'(op_count), 255);
    do_op(NOP, 1'b0, 1'b1);
    check("cnt_sat_last", int'(op_count), 255);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
